alu_issue_ctrl: RTL and testbench

Sequencing front-end for the 8-bit combinational ALU. It accepts one command (opcode plus two 8-bit operands) at a time over a valid/ready handshake and drives the ALU inputs from registers. It waits an opcode-dependent number of settle cycles, then captures the 16-bit result and flags into a response register presented over a second valid/ready handshake. It sits directly upstream of the ALU and also registers the ALU's outputs, so the ALU itself stays purely combinational.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 118 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its issue controller:
// opcodes, payload structs, FSM encoding and datapath widths.
package alu_pkg;

  localparam int unsigned OPC_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned WAIT_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OPC_W-1:0] OP_MUL  = 3'b010;
  localparam logic [OPC_W-1:0] OP_AND  = 3'b011;
  localparam logic [OPC_W-1:0] OP_OR   = 3'b100;
  localparam logic [OPC_W-1:0] OP_NAND = 3'b101;
  localparam logic [OPC_W-1:0] OP_NOR  = 3'b110;
  localparam logic [OPC_W-1:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } cmd_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [RES_W-1:0] result;
    logic             flagc;
    logic             flagz;
  } rsp_t;

  // Only ADD/SUB produce a meaningful carry; the ALU holds flagC otherwise.
  function automatic logic carry_valid(input logic [OPC_W-1:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue/response sequencer in front of the combinational ALU: registers the
// ALU inputs, waits an opcode-dependent settle time, then captures the result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES  = 2,
  parameter int unsigned BASE_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPC_W-1:0]  cmd_opcode,
  input  logic [DATA_W-1:0] cmd_op1,
  input  logic [DATA_W-1:0] cmd_op2,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_flagc,
  input  logic              alu_flagz,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OPC_W-1:0]  rsp_opcode,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_flagc,
  output logic              rsp_flagz,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15 || BASE_CYCLES < 1 || BASE_CYCLES > 15 || CNT_W < 1)
  begin : g_bad_param
    $error("alu_issue_ctrl: MUL_CYCLES/BASE_CYCLES must be 1..15 and CNT_W >= 1");
  end

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  cmd_t               cmd_q, cmd_d;
  rsp_t               rsp_q, rsp_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.opcode = cmd_opcode;
          cmd_d.op1    = cmd_op1;
          cmd_d.op2    = cmd_op2;
          rsp_d.opcode = cmd_opcode;
          cnt_d        = (cmd_opcode == OP_MUL) ? WAIT_W'(MUL_CYCLES) : WAIT_W'(BASE_CYCLES);
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          rsp_d.result = alu_result;
          rsp_d.flagz  = alu_flagz;
          rsp_d.flagc  = carry_valid(cmd_q.opcode) ? alu_flagc : 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cmd_ready and busy are decoded from state, so cmd_ready reads 1 in reset
  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign alu_opcode   = cmd_q.opcode;
  assign alu_operand1 = cmd_q.op1;
  assign alu_operand2 = cmd_q.op2;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_opcode   = rsp_q.opcode;
  assign rsp_result   = rsp_q.result;
  assign rsp_flagc    = rsp_q.flagc;
  assign rsp_flagz    = rsp_q.flagz;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a
// reference model; CNT_W is narrowed to 4 so counter wrap is reachable.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned MUL_N  = 2;
  localparam int unsigned BASE_N = 1;
  localparam int unsigned CW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [OPC_W-1:0]  cmd_opcode = '0;
  logic [DATA_W-1:0] cmd_op1 = '0;
  logic [DATA_W-1:0] cmd_op2 = '0;
  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] alu_operand1;
  logic [DATA_W-1:0] alu_operand2;
  logic [RES_W-1:0]  alu_result;
  logic              alu_flagc;
  logic              alu_flagz;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [OPC_W-1:0]  rsp_opcode;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_flagc;
  logic              rsp_flagz;
  logic              busy;
  logic [CW-1:0]     op_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.MUL_CYCLES(MUL_N), .BASE_CYCLES(BASE_N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_flagc(alu_flagc), .alu_flagz(alu_flagz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode),
    .rsp_result(rsp_result), .rsp_flagc(rsp_flagc), .rsp_flagz(rsp_flagz),
    .busy(busy), .op_count(op_count)
  );

  // Expected {result, flagc, flagz} from plain integer arithmetic
  function automatic logic [17:0] ref_model(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    int ia, ib, r;
    logic c;
    logic [15:0] res;
    ia = int'(a);
    ib = int'(b);
    c  = 1'b0;
    case (op)
      OP_ADD:  begin r = ia + ib; c = (r > 255); end
      OP_SUB:  begin r = ia - ib; c = (ia < ib); end
      OP_MUL:  r = ia * ib;
      OP_AND:  r = ia & ib;
      OP_OR:   r = ia | ib;
      OP_NAND: r = (~(ia & ib)) & 255;
      OP_NOR:  r = (~(ia | ib)) & 255;
      default: r = ia ^ ib;
    endcase
    res = 16'(r);
    return {res, c, (res == 16'h0000)};
  endfunction

  // Behavioural ALU; non-arithmetic ops present a stale carry of 1
  logic [17:0] alu_m;
  always_comb begin
    alu_m      = ref_model(alu_opcode, alu_operand1, alu_operand2);
    alu_result = alu_m[17:2];
    alu_flagc  = ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB)) ? alu_m[1] : 1'b1;
    alu_flagz  = alu_m[0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction; starts and ends aligned to a falling edge
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input bit keep,
                        input logic [15:0] eres, input logic ec, input logic ez);
    int lat;
    int n_exp;
    n_exp = (op == OP_MUL) ? int'(MUL_N) : int'(BASE_N);
    cmd_opcode = op; cmd_op1 = a; cmd_op2 = b; cmd_valid = 1'b1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    if (keep) begin
      cmd_opcode = ~op; cmd_op1 = ~a; cmd_op2 = b + 8'd1;
    end else cmd_valid = 1'b0;
    check("alu_latch", 32'({alu_opcode, alu_operand1, alu_operand2}), 32'({op, a, b}));
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      check("exec_busy", 32'({busy, cmd_ready}), 32'h2);
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(n_exp));
    for (int h = 0; h < hold; h++) begin
      check("rsp_hold", 32'({rsp_valid, cmd_ready, rsp_opcode, rsp_result, rsp_flagc, rsp_flagz, op_count}),
            32'({1'b1, 1'b0, op, eres, ec, ez, CW'(exp_count)}));
      @(posedge clk); @(negedge clk);
    end
    check("rsp_payload", 32'({rsp_valid, rsp_opcode, rsp_result, rsp_flagc, rsp_flagz}),
          32'({1'b1, op, eres, ec, ez}));
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 16;
    check("post_hs", 32'({rsp_valid, cmd_ready, busy}), 32'h2);
    check("op_count", 32'(op_count), 32'(exp_count));
    check("alu_held", 32'({alu_opcode, alu_operand1, alu_operand2}), 32'({op, a, b}));
    cmd_valid = 1'b0;
  endtask

  // Start an op, then assert reset after `wait_cyc` further cycles
  task automatic abort_op(input logic [2:0] op, input int wait_cyc);
    logic seen;
    cmd_opcode = op; cmd_op1 = 8'h12; cmd_op2 = 8'h34; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      @(posedge clk); @(negedge clk);
    end
    check("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_reset", 32'({rsp_valid, busy, cmd_ready, alu_opcode, alu_operand1, op_count}),
          32'({1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 4'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid | busy;
    end
    check("abort_no_rsp", 32'({seen, op_count}), 32'h0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          hold;
    bit          keep;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [17:0] m;
    logic [2:0]  rop;
    logic [7:0]  ra, rb;
    tbl[0]  = '{OP_ADD,  8'hFF, 8'h01, 0, 1'b0, 16'h0100, 1'b1, 1'b0};
    tbl[1]  = '{OP_MUL,  8'hFF, 8'hFF, 2, 1'b1, 16'hFE01, 1'b0, 1'b0};
    tbl[2]  = '{OP_SUB,  8'h00, 8'h01, 5, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[3]  = '{OP_ADD,  8'h80, 8'h80, 0, 1'b0, 16'h0100, 1'b1, 1'b0};
    tbl[4]  = '{OP_XOR,  8'hA5, 8'hA5, 0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{OP_AND,  8'hF0, 8'h3C, 1, 1'b0, 16'h0030, 1'b0, 1'b0};
    tbl[6]  = '{OP_OR,   8'h0F, 8'hF0, 0, 1'b1, 16'h00FF, 1'b0, 1'b0};
    tbl[7]  = '{OP_NAND, 8'hFF, 8'hFF, 0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[8]  = '{OP_NOR,  8'h00, 8'h00, 0, 1'b0, 16'h00FF, 1'b0, 1'b0};
    tbl[9]  = '{OP_SUB,  8'h05, 8'h03, 0, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[10] = '{OP_MUL,  8'h00, 8'h37, 2, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{OP_ADD,  8'h00, 8'h00, 0, 1'b0, 16'h0000, 1'b0, 1'b1};

    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_state", 32'({rsp_valid, rsp_result, op_count, busy, cmd_ready}),
          32'({1'b0, 16'h0000, 4'h0, 1'b0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("no_spurious_rsp", 32'({rsp_valid, busy, op_count}), 32'h0);

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].keep,
             tbl[i].res, tbl[i].c, tbl[i].z);

    abort_op(OP_MUL, 0);
    abort_op(OP_ADD, 2);

    // 40 random ops after reset: op_count wraps past 15 along the way
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      m   = ref_model(rop, ra, rb);
      run_op(rop, ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             m[17:2], m[1], m[0]);
      if (i == 15) check("wrap_to_zero", 32'(op_count), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
